arb4_rr_ctrl: RTL and testbench

Four-requester arbiter that shares the single 4-line priority-encoded resource (the 4-to-2 encoder datapath) among four requesters. Selects one winner by fixed priority (index 3 highest, same order as the encoder) or by round-robin, holds the grant until the owner releases or a hold timeout fires, then re-arbitrates. Sits between the requesters and the shared resource. Drives a one-hot grant plus the encoded owner ID and a valid flag.

---
 rtl/arb4_rr_ctrl.sv | 142 ++++++++++++++
 tb/tb_arb4_rr_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/arb4_rr_ctrl.sv
// Four-requester arbiter for the shared 4-to-2 encoder resource.
// It supports fixed priority or round-robin selection, a hold timeout, and an idle gap between grants.
module arb4_rr_ctrl #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       rr_en,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic       gnt_valid_q, gnt_valid_d;
   logic       timeout_q, timeout_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [1:0] last_id_q, last_id_d;

   logic [1:0] rr_start;
   logic [3:0] rr_req;
   logic [1:0] rr_off;
   logic [1:0] rr_win;
   logic [1:0] fp_win;
   logic [1:0] win;
   logic       owner_req;
   logic       hold_at_limit;

   // Rotate the requests so that bit 0 is the first candidate after the last owner.
   assign rr_start = last_id_q + 2'd1;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rot
         assign rr_req[gi] = req[rr_start + 2'(gi)];
      end
   endgenerate

   always_comb begin
      rr_off = 2'd3;
      casez (rr_req)
         4'b???1: rr_off = 2'd0;
         4'b??10: rr_off = 2'd1;
         4'b?100: rr_off = 2'd2;
         default: rr_off = 2'd3;
      endcase
   end

   assign rr_win = rr_start + rr_off;

   always_comb begin
      fp_win = 2'd0;
      casez (req)
         4'b1???: fp_win = 2'd3;
         4'b01??: fp_win = 2'd2;
         4'b001?: fp_win = 2'd1;
         default: fp_win = 2'd0;
      endcase
   end

   assign win           = rr_en ? rr_win : fp_win;
   assign owner_req     = req[gnt_id_q];
   assign hold_at_limit = (hold_cnt_q == HOLD_LAST);

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      last_id_d   = last_id_q;

      case (state_q)
         ST_IDLE: begin
            gnt_d       = 4'b0000;
            gnt_id_d    = 2'd0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = 8'd0;
            if (|req) begin
               state_d     = ST_GRANT;
               gnt_d       = 4'b0001 << win;
               gnt_id_d    = win;
               gnt_valid_d = 1'b1;
               last_id_d   = win;
            end
         end
         ST_GRANT: begin
            // Release is checked first, so a release on the last allowed cycle does not raise timeout.
            if (!owner_req || hold_at_limit) begin
               state_d     = ST_IDLE;
               gnt_d       = 4'b0000;
               gnt_id_d    = 2'd0;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = 8'd0;
               timeout_d   = owner_req;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         gnt_q       <= 4'b0000;
         gnt_id_q    <= 2'd0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= 8'd0;
         last_id_q   <= 2'd3;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
         last_id_q   <= last_id_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Directed bench for arb4_rr_ctrl with two instances: one with MAX_HOLD=8 and one with MAX_HOLD=4.
// Each step queues its expected registered outputs and checks them one edge later.
module tb_arb4_rr_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       rr_en = 1'b0;

   logic [3:0] gnt8, gnt4;
   logic [1:0] gnt_id8, gnt_id4;
   logic       gnt_valid8, gnt_valid4;
   logic       timeout8, timeout4;

   int errors = 0;
   int checks = 0;
   string cur_tag;

   typedef struct {
      int         which;
      logic [3:0] gnt;
      logic       to;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   arb4_rr_ctrl #(.MAX_HOLD(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
      .gnt(gnt8), .gnt_id(gnt_id8), .gnt_valid(gnt_valid8), .timeout(timeout8)
   );

   arb4_rr_ctrl #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
      .gnt(gnt4), .gnt_id(gnt_id4), .gnt_valid(gnt_valid4), .timeout(timeout4)
   );

   function automatic logic [1:0] id_of(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   task automatic check_front();
      exp_t       e;
      logic [3:0] o_gnt;
      logic [1:0] o_id;
      logic       o_val;
      logic       o_to;
      logic [1:0] e_id;
      logic       e_val;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty observed=0 expected=1", cur_tag);
         return;
      end
      e = exp_q.pop_front();
      if (e.which == 0) begin
         o_gnt = gnt8; o_id = gnt_id8; o_val = gnt_valid8; o_to = timeout8;
      end else begin
         o_gnt = gnt4; o_id = gnt_id4; o_val = gnt_valid4; o_to = timeout4;
      end
      e_id  = id_of(e.gnt);
      e_val = |e.gnt;
      checks++;
      assert (o_gnt === e.gnt) else begin
         errors++;
         $error("FAIL %s gnt observed=%b expected=%b", cur_tag, o_gnt, e.gnt);
      end
      checks++;
      assert (o_id === e_id) else begin
         errors++;
         $error("FAIL %s gnt_id observed=%0d expected=%0d", cur_tag, o_id, e_id);
      end
      checks++;
      assert (o_val === e_val) else begin
         errors++;
         $error("FAIL %s gnt_valid observed=%b expected=%b", cur_tag, o_val, e_val);
      end
      checks++;
      assert (o_to === e.to) else begin
         errors++;
         $error("FAIL %s timeout observed=%b expected=%b", cur_tag, o_to, e.to);
      end
      $display("step %-10s dut%0d req=%b rr=%b gnt=%b id=%0d v=%b to=%b",
               cur_tag, (e.which == 0) ? 8 : 4, req, rr_en, o_gnt, o_id, o_val, o_to);
   endtask

   task automatic step(input string tag, input int which, input logic [3:0] r,
                       input logic rr, input logic [3:0] eg, input logic eto);
      exp_t e;
      cur_tag = tag;
      req     = r;
      rr_en   = rr;
      e.which = which;
      e.gnt   = eg;
      e.to    = eto;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_front();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and idle
      rst_n = 1'b0;
      step("rst0", 0, 4'b1111, 1'b0, 4'b0000, 1'b0);
      step("rst1", 0, 4'b1111, 1'b0, 4'b0000, 1'b0);
      rst_n = 1'b1;
      step("idle0", 0, 4'b0000, 1'b0, 4'b0000, 1'b0);
      step("idle1", 0, 4'b0000, 1'b0, 4'b0000, 1'b0);

      // Fixed priority, release, and other requests ignored while granted
      step("fp_g2",  0, 4'b0101, 1'b0, 4'b0100, 1'b0);
      step("fp_h2",  0, 4'b0101, 1'b0, 4'b0100, 1'b0);
      step("fp_rel", 0, 4'b0001, 1'b0, 4'b0000, 1'b0);
      step("fp_g0",  0, 4'b0001, 1'b0, 4'b0001, 1'b0);
      step("fp_ign", 0, 4'b1001, 1'b0, 4'b0001, 1'b0);
      step("fp_rl0", 0, 4'b1000, 1'b0, 4'b0000, 1'b0);
      step("fp_g3",  0, 4'b1000, 1'b0, 4'b1000, 1'b0);
      step("fp_rl3", 0, 4'b0000, 1'b0, 4'b0000, 1'b0);
      step("fp_idl", 0, 4'b0000, 1'b0, 4'b0000, 1'b0);

      // Round-robin rotation 0,1,2,3,0 after reset
      rst_n = 1'b0;
      step("rr_rst", 0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      rst_n = 1'b1;
      step("rr_g0a", 0, 4'b1111, 1'b1, 4'b0001, 1'b0);
      step("rr_g0b", 0, 4'b1111, 1'b1, 4'b0001, 1'b0);
      step("rr_r0",  0, 4'b1110, 1'b1, 4'b0000, 1'b0);
      step("rr_g1a", 0, 4'b1111, 1'b1, 4'b0010, 1'b0);
      step("rr_g1b", 0, 4'b1111, 1'b1, 4'b0010, 1'b0);
      step("rr_r1",  0, 4'b1101, 1'b1, 4'b0000, 1'b0);
      step("rr_g2a", 0, 4'b1111, 1'b1, 4'b0100, 1'b0);
      step("rr_g2b", 0, 4'b1111, 1'b1, 4'b0100, 1'b0);
      step("rr_r2",  0, 4'b1011, 1'b1, 4'b0000, 1'b0);
      step("rr_g3a", 0, 4'b1111, 1'b1, 4'b1000, 1'b0);
      step("rr_g3b", 0, 4'b1111, 1'b1, 4'b1000, 1'b0);
      step("rr_r3",  0, 4'b0111, 1'b1, 4'b0000, 1'b0);
      step("rr_g0c", 0, 4'b1111, 1'b1, 4'b0001, 1'b0);
      step("rr_r0b", 0, 4'b1110, 1'b1, 4'b0000, 1'b0);
      step("rr_idl", 0, 4'b0000, 1'b1, 4'b0000, 1'b0);

      // Timeout with MAX_HOLD=8 in fixed mode, followed by a re-grant
      for (int i = 0; i < 8; i++)
         step($sformatf("to_h%0d", i), 0, 4'b1000, 1'b0, 4'b1000, 1'b0);
      step("to_pls", 0, 4'b1000, 1'b0, 4'b0000, 1'b1);
      step("to_rg",  0, 4'b1000, 1'b0, 4'b1000, 1'b0);
      step("to_rel", 0, 4'b0000, 1'b0, 4'b0000, 1'b0);
      step("to_idl", 0, 4'b0000, 1'b0, 4'b0000, 1'b0);

      // Round-robin fairness under timeout with MAX_HOLD=4
      rst_n = 1'b0;
      step("fa_rst", 1, 4'b0000, 1'b1, 4'b0000, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 4; i++)
            step($sformatf("fa%0d_h%0d", k, i), 1, 4'b1001, 1'b1,
                 (k % 2 == 0) ? 4'b0001 : 4'b1000, 1'b0);
         step($sformatf("fa%0d_to", k), 1, 4'b1001, 1'b1, 4'b0000, 1'b1);
      end
      step("fa_g0",  1, 4'b1001, 1'b1, 4'b0001, 1'b0);
      step("fa_rel", 1, 4'b0000, 1'b1, 4'b0000, 1'b0);

      // Reset during a grant restarts the round-robin scan at 0
      rst_n = 1'b0;
      step("mr_rst0", 0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      rst_n = 1'b1;
      step("mr_g2a", 0, 4'b0100, 1'b1, 4'b0100, 1'b0);
      step("mr_g2b", 0, 4'b0100, 1'b1, 4'b0100, 1'b0);
      rst_n = 1'b0;
      step("mr_rst1", 0, 4'b0100, 1'b1, 4'b0000, 1'b0);
      rst_n = 1'b1;
      step("mr_g0a", 0, 4'b1111, 1'b1, 4'b0001, 1'b0);
      step("mr_g0b", 0, 4'b1111, 1'b1, 4'b0001, 1'b0);
      step("mr_rel", 0, 4'b0000, 1'b1, 4'b0000, 1'b0);

      // A release on the last allowed cycle wins over timeout
      for (int i = 0; i < 8; i++)
         step($sformatf("co_h%0d", i), 0, 4'b0010, 1'b0, 4'b0010, 1'b0);
      step("co_rel", 0, 4'b0000, 1'b0, 4'b0000, 1'b0);
      step("co_idl", 0, 4'b0000, 1'b0, 4'b0000, 1'b0);

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain leftover observed=%0d expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
